// File: rtl/mnist_selftest_seq.sv
// mnist_selftest_seq: on-board self-test sequencer that sweeps every embedded image through the
// accelerator, checks each result against its label, then confirms that an out-of-range select reads invalid.
`default_nettype none

module mnist_selftest_seq #(
   parameter int                 N_IMG       = 3,
   parameter int                 SEL_W       = 2,
   parameter logic [4*N_IMG-1:0] LABELS      = 12'h326,
   parameter int                 TIMEOUT_CYC = 2000000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   output logic             acc_start,
   output logic [SEL_W-1:0] acc_img_sel,
   input  logic [3:0]       acc_digit,
   input  logic             acc_done,
   input  logic             acc_valid,
   output logic             busy,
   output logic             sweep_done,
   output logic [SEL_W-1:0] pass_cnt,
   output logic [SEL_W-1:0] fail_cnt,
   output logic [N_IMG-1:0] fail_mask,
   output logic             inval_ok,
   output logic             timeout_err,
   output logic [3:0]       last_digit
);

   localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TW-1:0]    TMO_LAST = TW'(TIMEOUT_CYC - 1);
   localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_IMG - 1);
   localparam logic [SEL_W-1:0] INV_SEL  = SEL_W'(N_IMG);
   localparam bit               HAS_INV  = (N_IMG < (2 ** SEL_W));

   localparam logic [3:0] S_IDLE   = 4'd0;
   localparam logic [3:0] S_SEL    = 4'd1;
   localparam logic [3:0] S_SETTLE = 4'd2;
   localparam logic [3:0] S_CHKV   = 4'd3;
   localparam logic [3:0] S_START  = 4'd4;
   localparam logic [3:0] S_WAITD  = 4'd5;
   localparam logic [3:0] S_CMP    = 4'd6;
   localparam logic [3:0] S_WAITI  = 4'd7;
   localparam logic [3:0] S_NEXT   = 4'd8;
   localparam logic [3:0] S_INV    = 4'd9;
   localparam logic [3:0] S_INVC   = 4'd10;
   localparam logic [3:0] S_FIN    = 4'd11;

   logic [3:0]       state;
   logic [SEL_W-1:0] idx;
   logic [SEL_W-1:0] sel;
   logic [TW-1:0]    tmo;
   logic [3:0]       label;
   logic [N_IMG-1:0] idx_bit;

   // Strobes decode straight from state so a reset drops them on the very next edge.
   assign acc_start   = (state == S_START);
   assign sweep_done  = (state == S_FIN);
   assign busy        = (state != S_IDLE) && (state != S_FIN);
   assign acc_img_sel = sel;
   assign idx_bit     = N_IMG'(1) << idx;

   always_comb begin
      label = 4'd0;
      for (int i = 0; i < N_IMG; i++) begin
         if (idx == SEL_W'(i)) label = LABELS[4*i +: 4];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         idx         <= '0;
         sel         <= '0;
         tmo         <= '0;
         pass_cnt    <= '0;
         fail_cnt    <= '0;
         fail_mask   <= '0;
         inval_ok    <= 1'b0;
         timeout_err <= 1'b0;
         last_digit  <= 4'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (run) begin
                  pass_cnt    <= '0;
                  fail_cnt    <= '0;
                  fail_mask   <= '0;
                  inval_ok    <= 1'b0;
                  timeout_err <= 1'b0;
                  idx         <= '0;
                  state       <= S_SEL;
               end
            end
            S_SEL: begin
               sel   <= idx;
               state <= S_SETTLE;
            end
            S_SETTLE: state <= S_CHKV;
            S_CHKV: begin
               if (!acc_valid) begin
                  fail_cnt  <= fail_cnt + 1'b1;
                  fail_mask <= fail_mask | idx_bit;
                  state     <= S_NEXT;
               end else if (!acc_done) begin
                  state <= S_START;
               end
            end
            S_START: begin
               tmo   <= '0;
               state <= S_WAITD;
            end
            S_WAITD: begin
               if (acc_done) begin
                  last_digit <= acc_digit;
                  state      <= S_CMP;
               end else if (tmo == TMO_LAST) begin
                  // Accelerator state is unknown after a hang, so the rest of the sweep is dropped.
                  timeout_err <= 1'b1;
                  fail_cnt    <= fail_cnt + 1'b1;
                  fail_mask   <= fail_mask | idx_bit;
                  state       <= S_FIN;
               end else begin
                  tmo <= tmo + 1'b1;
               end
            end
            S_CMP: begin
               if (last_digit == label) begin
                  pass_cnt <= pass_cnt + 1'b1;
               end else begin
                  fail_cnt  <= fail_cnt + 1'b1;
                  fail_mask <= fail_mask | idx_bit;
               end
               state <= S_WAITI;
            end
            S_WAITI: if (!acc_done) state <= S_NEXT;
            S_NEXT: begin
               if (idx == LAST_IDX) begin
                  state <= HAS_INV ? S_INV : S_FIN;
               end else begin
                  idx   <= idx + 1'b1;
                  state <= S_SEL;
               end
            end
            S_INV: begin
               sel   <= INV_SEL;
               state <= S_INVC;
            end
            S_INVC: begin
               inval_ok <= ~acc_valid;
               state    <= S_FIN;
            end
            S_FIN:   state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mnist_selftest_seq.sv
// tb_mnist_selftest_seq: drives mnist_selftest_seq against a behavioural accelerator and
// checks sweep results against a per-image reference computed from the label table.
`default_nettype none

module tb_mnist_selftest_seq;
   localparam int N_IMG = 3;
   localparam int SEL_W = 2;
   localparam int TMO   = 100;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic run = 1'b0;
   logic acc_start, busy, sweep_done, inval_ok, timeout_err;
   logic [SEL_W-1:0] acc_img_sel, pass_cnt, fail_cnt;
   logic [N_IMG-1:0] fail_mask;
   logic [3:0] last_digit;
   logic [3:0] acc_digit = 4'd0;
   logic done_m = 1'b0, force_done = 1'b0, valid_bad = 1'b0;
   logic acc_done, acc_valid;

   assign acc_done  = done_m | force_done;
   assign acc_valid = (acc_img_sel < SEL_W'(N_IMG)) | valid_bad;

   mnist_selftest_seq #(.N_IMG(N_IMG), .SEL_W(SEL_W), .LABELS(12'h326), .TIMEOUT_CYC(TMO)) dut (
      .clk(clk), .rst(rst), .run(run), .acc_start(acc_start), .acc_img_sel(acc_img_sel),
      .acc_digit(acc_digit), .acc_done(acc_done), .acc_valid(acc_valid), .busy(busy),
      .sweep_done(sweep_done), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .fail_mask(fail_mask),
      .inval_ok(inval_ok), .timeout_err(timeout_err), .last_digit(last_digit)
   );

   always #5 clk = ~clk;

   int lab[N_IMG] = '{6, 2, 3};
   int dig[N_IMG] = '{6, 2, 3};
   int lat = 50, hold = 3, hang_img = -1;
   int n_checks = 0, n_fail = 0;
   int exp_last = 0;
   int cyc = 0, n_start = 0, n_sdone = 0, bad_width = 0, start_in_done = 0;
   int last_start_cyc = 0, sdone_cyc = 0;

   // Accelerator model: answers lat cycles after start, holds done for hold cycles.
   initial begin
      int cnt, hcnt, img;
      cnt = 0; hcnt = 0; img = 0;
      forever begin
         @(posedge clk);
         #1;
         if (rst) begin
            cnt = 0; hcnt = 0; done_m = 1'b0;
         end else begin
            if (hcnt > 0) begin
               hcnt--;
               if (hcnt == 0) done_m = 1'b0;
            end else if (cnt > 0) begin
               cnt--;
               if (cnt == 0) begin
                  done_m = 1'b1; acc_digit = 4'(dig[img]); hcnt = hold;
               end
            end
            if (acc_start) begin
               img = int'(acc_img_sel);
               if (img != hang_img) cnt = lat;
            end
         end
      end
   end

   initial begin
      bit prev;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         if (acc_start) begin
            n_start++; last_start_cyc = cyc;
            if (prev) bad_width++;
            if (acc_done) start_in_done++;
         end
         prev = acc_start;
         if (sweep_done) begin n_sdone++; sdone_cyc = cyc; end
      end
   end

   // Reference: walk the images in order; a hang aborts the sweep and skips the invalid probe.
   function automatic void ref_sweep(output int ep, output int ef, output int em,
                                     output int ei, output int et, output int es);
      bit ab;
      ep = 0; ef = 0; em = 0; et = 0; es = 0; ab = 1'b0;
      for (int i = 0; i < N_IMG; i++) begin
         es++;
         if (hang_img == i) begin
            ef++; em |= (1 << i); et = 1; ab = 1'b1; break;
         end
         exp_last = dig[i];
         if (dig[i] == lab[i]) ep++;
         else begin ef++; em |= (1 << i); end
      end
      ei = (ab || valid_bad) ? 0 : 1;
   endfunction

   task automatic do_sweep(output bit got, output int lat_start);
      int k;
      got = 1'b0; lat_start = -1;
      @(negedge clk); run = 1'b1;
      @(negedge clk); run = 1'b0; k = 1;
      for (int c = 0; c < 5000; c++) begin
         if (acc_start && lat_start < 0) lat_start = k;
         if (sweep_done) begin got = 1'b1; break; end
         @(negedge clk); k++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({busy, acc_start, sweep_done, inval_ok, timeout_err} !== 5'b0) begin
         n_fail++; $display("FAIL reset_flags: got %b expected 00000", {busy, acc_start, sweep_done, inval_ok, timeout_err});
      end
      n_checks++;
      if ({pass_cnt, fail_cnt, fail_mask, last_digit, acc_img_sel} !== 15'b0) begin
         n_fail++; $display("FAIL reset_values: got %h expected 0", {pass_cnt, fail_cnt, fail_mask, last_digit, acc_img_sel});
      end
      rst = 1'b0;
      exp_last = 0;
      @(negedge clk);
   endtask

   task automatic test_sweep(input string name);
      int ep, ef, em, ei, et, es, s0, d0, w0, l0, ls;
      bit got;
      ref_sweep(ep, ef, em, ei, et, es);
      s0 = n_start; d0 = n_sdone; w0 = bad_width; l0 = start_in_done;
      do_sweep(got, ls);
      n_checks++;
      if (!got) begin n_fail++; $display("FAIL %s sweep_done: no pulse within bound", name); end
      n_checks++;
      if (pass_cnt !== SEL_W'(ep) || fail_cnt !== SEL_W'(ef)) begin
         n_fail++; $display("FAIL %s counts: got pass=%0d fail=%0d expected pass=%0d fail=%0d", name, pass_cnt, fail_cnt, ep, ef);
      end
      n_checks++;
      if (fail_mask !== N_IMG'(em)) begin
         n_fail++; $display("FAIL %s fail_mask: got %b expected %b", name, fail_mask, N_IMG'(em));
      end
      n_checks++;
      if (inval_ok !== 1'(ei) || timeout_err !== 1'(et) || busy !== 1'b0) begin
         n_fail++; $display("FAIL %s flags: got inval=%b tmo=%b busy=%b expected %0d %0d 0", name, inval_ok, timeout_err, busy, ei, et);
      end
      n_checks++;
      if (last_digit !== 4'(exp_last)) begin
         n_fail++; $display("FAIL %s last_digit: got %0d expected %0d", name, last_digit, exp_last);
      end
      n_checks++;
      if (ls != 4) begin n_fail++; $display("FAIL %s run_to_start: got %0d expected 4", name, ls); end
      repeat (20) @(negedge clk);
      n_checks++;
      if (n_start - s0 != es || bad_width != w0 || start_in_done != l0) begin
         n_fail++; $display("FAIL %s starts: got %0d (wide %0d, in_done %0d) expected %0d (0, 0)", name, n_start - s0, bad_width - w0, start_in_done - l0, es);
      end
      n_checks++;
      if (n_sdone - d0 != 1 || pass_cnt !== SEL_W'(ep)) begin
         n_fail++; $display("FAIL %s hold: got sweeps=%0d pass=%0d expected 1 %0d", name, n_sdone - d0, pass_cnt, ep);
      end
   endtask

   task automatic test_timeout();
      dig = '{6, 2, 3}; hang_img = 1;
      test_sweep("timeout");
      n_checks++;
      if (sdone_cyc - last_start_cyc < 98 || sdone_cyc - last_start_cyc > 104) begin
         n_fail++; $display("FAIL timeout_latency: got %0d expected about %0d", sdone_cyc - last_start_cyc, TMO);
      end
      hang_img = -1;
   endtask

   task automatic test_reset_midsweep();
      int s0;
      dig = '{6, 2, 3}; lat = 50; hold = 3;
      s0 = n_start;
      @(negedge clk); run = 1'b1;
      @(negedge clk); run = 1'b0;
      for (int c = 0; c < 2000 && n_start - s0 < 2; c++) @(negedge clk);
      n_checks++;
      if (n_start - s0 != 2) begin n_fail++; $display("FAIL midsweep_reach: got %0d starts expected 2", n_start - s0); end
      repeat (5) @(negedge clk);
      n_checks++;
      if (pass_cnt !== 2'd1) begin n_fail++; $display("FAIL midsweep_pre: got pass=%0d expected 1", pass_cnt); end
      rst = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({busy, acc_start, timeout_err, inval_ok} !== 4'b0 || {pass_cnt, fail_cnt, fail_mask} !== 7'b0) begin
         n_fail++; $display("FAIL midsweep_reset: got busy=%b start=%b pass=%0d fail=%0d mask=%b expected all 0", busy, acc_start, pass_cnt, fail_cnt, fail_mask);
      end
      rst = 1'b0;
      exp_last = 0;
      repeat (60) @(negedge clk);
      test_sweep("after_reset");
   endtask

   task automatic test_back_to_back();
      int s0, d0, l0;
      bit got;
      dig = '{6, 2, 3}; valid_bad = 1'b0;
      s0 = n_start; d0 = n_sdone; l0 = start_in_done;
      force_done = 1'b1;
      @(negedge clk); run = 1'b1;
      @(negedge clk); run = 1'b0;
      repeat (10) @(negedge clk);
      n_checks++;
      if (n_start != s0 || busy !== 1'b1) begin
         n_fail++; $display("FAIL b2b_stall: got starts=%0d busy=%b expected 0 1", n_start - s0, busy);
      end
      run = 1'b1;
      @(negedge clk); run = 1'b0;
      repeat (3) @(negedge clk);
      force_done = 1'b0;
      got = 1'b0;
      for (int c = 0; c < 5000; c++) begin
         if (sweep_done) begin got = 1'b1; break; end
         @(negedge clk);
      end
      n_checks++;
      if (!got || pass_cnt !== 2'd3 || fail_cnt !== 2'd0) begin
         n_fail++; $display("FAIL b2b_result: got done=%b pass=%0d fail=%0d expected 1 3 0", got, pass_cnt, fail_cnt);
      end
      repeat (300) @(negedge clk);
      n_checks++;
      if (n_sdone - d0 != 1 || n_start - s0 != 3 || start_in_done != l0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL b2b_single: got sweeps=%0d starts=%0d in_done=%0d busy=%b expected 1 3 0 0", n_sdone - d0, n_start - s0, start_in_done - l0, busy);
      end
      exp_last = 3;
   endtask

   task automatic test_random();
      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < N_IMG; i++) dig[i] = ($urandom_range(0, 1) == 1) ? lab[i] : int'($urandom_range(0, 9));
         lat       = int'($urandom_range(1, 60));
         hold      = int'($urandom_range(1, 4));
         valid_bad = ($urandom_range(0, 3) == 0);
         hang_img  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, N_IMG - 1)) : -1;
         test_sweep("random");
      end
      hang_img = -1; valid_bad = 1'b0; lat = 50; hold = 3;
   endtask

   initial begin
      test_reset();
      dig = '{6, 2, 3};
      test_sweep("all_pass");
      dig = '{6, 5, 3};
      test_sweep("mismatch");
      test_timeout();
      dig = '{6, 2, 3}; valid_bad = 1'b1;
      test_sweep("inval_bad");
      valid_bad = 1'b0;
      test_reset_midsweep();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
